// File: rtl/calc_key_arbiter_if.sv
// Key-source bundle between the keypad/host sources and the arbiter.
// The master side drives the key sources; the slave side is the arbiter.
interface calc_key_arbiter_if;
  logic       a_valid;
  logic [4:0] a_code;
  logic       b_valid;
  logic [4:0] b_code;
  logic       b_ready;
  logic       new_key;
  logic [4:0] keycode;
  logic       a_overflow;
  logic       busy;

  modport master (
    output a_valid, a_code, b_valid, b_code,
    input  b_ready, new_key, keycode, a_overflow, busy
  );

  modport slave (
    input  a_valid, a_code, b_valid, b_code,
    output b_ready, new_key, keycode, a_overflow, busy
  );
endinterface

// File: rtl/calc_key_arbiter.sv
// Two-source key arbiter: per-source FIFOs feeding a round-robin
// sequencer that replays keys with setup/strobe/hold timing.
module calc_key_arbiter #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input logic           clock,
  input logic           reset,
  calc_key_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t        state;
  logic          rr;
  logic [HW-1:0] hold;
  logic          new_key;
  logic [4:0]    keycode;
  logic          a_overflow;

  logic [4:0]    mem_a [DEPTH];
  logic [AW-1:0] wp_a;
  logic [AW-1:0] rp_a;
  logic [CW-1:0] cnt_a;

  logic [4:0]    mem_b [DEPTH];
  logic [AW-1:0] wp_b;
  logic [AW-1:0] rp_b;
  logic [CW-1:0] cnt_b;

  logic empty_a;
  logic empty_b;
  logic full_a;
  logic full_b;
  logic pop_a;
  logic pop_b;
  logic wr_a;
  logic wr_b;
  logic b_ready;

  assign empty_a = (cnt_a == '0);
  assign empty_b = (cnt_b == '0);
  assign full_a  = (cnt_a == CW'(DEPTH));
  assign full_b  = (cnt_b == CW'(DEPTH));

  // rr = 0 favours A, rr = 1 favours B when both hold keys
  assign pop_a = (state == IDLE) && !empty_a && (empty_b || !rr);
  assign pop_b = (state == IDLE) && !empty_b && (empty_a || rr);

  assign wr_a    = bus.a_valid && (!full_a || pop_a);
  assign b_ready = !full_b || pop_b;
  assign wr_b    = bus.b_valid && b_ready;

  always_ff @(posedge clock) begin
    if (wr_a) mem_a[wp_a] <= bus.a_code;
    if (wr_b) mem_b[wp_b] <= bus.b_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_a  <= '0;
      rp_a  <= '0;
      cnt_a <= '0;
      wp_b  <= '0;
      rp_b  <= '0;
      cnt_b <= '0;
    end else begin
      if (wr_a)  wp_a <= wp_a + AW'(1);
      if (pop_a) rp_a <= rp_a + AW'(1);
      if (wr_b)  wp_b <= wp_b + AW'(1);
      if (pop_b) rp_b <= rp_b + AW'(1);
      cnt_a <= cnt_a + CW'(wr_a) - CW'(pop_a);
      cnt_b <= cnt_b + CW'(wr_b) - CW'(pop_b);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_overflow <= 1'b0;
    end else if (bus.a_valid && !wr_a) begin
      a_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr      <= 1'b0;
      hold    <= '0;
      new_key <= 1'b0;
      keycode <= 5'b00000;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop_a || pop_b) begin
            keycode <= pop_a ? mem_a[rp_a] : mem_b[rp_b];
            rr      <= pop_a;
            state   <= SETUP;
          end
        end
        SETUP: begin
          new_key <= 1'b1;
          state   <= STROBE;
        end
        STROBE: begin
          new_key <= 1'b0;
          hold    <= HW'(GAP - 1);
          state   <= HOLD;
        end
        HOLD: begin
          if (hold == '0) state <= IDLE;
          else            hold  <= hold - HW'(1);
        end
      endcase
    end
  end

  assign bus.new_key    = new_key;
  assign bus.keycode    = keycode;
  assign bus.a_overflow = a_overflow;
  assign bus.b_ready    = b_ready;
  assign bus.busy       = (state != IDLE) || !empty_a || !empty_b;

endmodule
